// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues at most one instruction-bus
// request at a time and captures returned words into a one-entry slot
// consumed by pre-decode as {f_pc, f_instr}. Redirects flush the slot and
// discard any wrong-path response still owed by the bus.
//
// Bus handshake: a request is presented with ireq.valid/ireq.addr and is
// accepted in a cycle with iresp.addr_ok; once presented it is held with a
// stable address until accepted. Its data returns with iresp.data_ok in the
// accept cycle or any later cycle, and only one request may be outstanding.

package fetch_pkg;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    addr_t       addr;
    logic [31:0] wdata;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_HELD  = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC = 32'hbfc0_0000
) (
  input  logic         clk,
  input  logic         resetn,
  output ibus_req_t    ireq,
  input  ibus_resp_t   iresp,
  input  logic         redirect_valid,
  input  addr_t        redirect_pc,
  input  logic         stall,
  output logic         f_valid,
  output addr_t        f_pc,
  output logic [31:0]  f_instr,
  output fetch_state_e dbg_state_o,
  output addr_t        dbg_pc_o,
  output logic         dbg_kill_o
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  addr_t        req_addr_q, req_addr_d;
  logic         kill_q, kill_d;
  logic         f_valid_q, f_valid_d;
  addr_t        f_pc_q, f_pc_d;
  logic [31:0]  f_instr_q, f_instr_d;

  logic         slot_free;
  logic         req_valid;
  addr_t        req_addr;
  logic         fill;
  addr_t        fill_addr;

  assign slot_free = !f_valid_q || !stall;

  // Next-state, bus request and slot update; defaults hold every register.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    req_valid  = 1'b0;
    req_addr   = pc_q;
    fill       = 1'b0;
    fill_addr  = req_addr_q;

    case (state_q)
      ST_READY: begin
        req_valid = slot_free && !redirect_valid;
        req_addr  = pc_q;
        if (req_valid) begin
          req_addr_d = pc_q;
          if (iresp.addr_ok) begin
            pc_d = pc_q + 32'd4;
            if (iresp.data_ok) begin
              fill      = 1'b1;
              fill_addr = pc_q;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        // The held address stays on the bus even after a redirect.
        req_valid = 1'b1;
        req_addr  = req_addr_q;
        if (iresp.addr_ok) begin
          if (!kill_q) pc_d = pc_q + 32'd4;
          if (iresp.data_ok) begin
            fill    = !kill_q && !redirect_valid;
            kill_d  = 1'b0;
            state_d = ST_READY;
          end else begin
            kill_d  = kill_q || redirect_valid;
            state_d = ST_WAIT;
          end
        end else begin
          kill_d = kill_q || redirect_valid;
        end
      end
      ST_WAIT: begin
        if (iresp.data_ok) begin
          fill    = !kill_q && !redirect_valid;
          kill_d  = 1'b0;
          state_d = ST_READY;
        end else begin
          kill_d = kill_q || redirect_valid;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase

    // Latest redirect always sets the next fetch address.
    if (redirect_valid) pc_d = redirect_pc;

    f_valid_d = f_valid_q;
    f_pc_d    = f_pc_q;
    f_instr_d = f_instr_q;
    if (fill) begin
      f_valid_d = 1'b1;
      f_pc_d    = fill_addr;
      f_instr_d = iresp.data;
    end else if (f_valid_q && !stall) begin
      f_valid_d = 1'b0;
    end
    if (redirect_valid) f_valid_d = 1'b0;
  end

  // State, PC, kill flag and output slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_READY;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
      f_valid_q  <= 1'b0;
      f_pc_q     <= '0;
      f_instr_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      f_valid_q  <= f_valid_d;
      f_pc_q     <= f_pc_d;
      f_instr_q  <= f_instr_d;
    end
  end

  // Request bus: only valid and addr are ever driven non-zero.
  always_comb begin
    ireq       = '0;
    ireq.valid = resetn && req_valid;
    ireq.addr  = req_addr;
  end

  // A response is only legal while waiting or in the accept cycle itself.
  always @(posedge clk) begin
    if (resetn && iresp.data_ok)
      assert (state_q == ST_WAIT || (req_valid && iresp.addr_ok));
  end

  assign f_valid     = f_valid_q;
  assign f_pc        = f_pc_q;
  assign f_instr     = f_instr_q;
  assign dbg_state_o = state_q;
  assign dbg_pc_o    = pc_q;
  assign dbg_kill_o  = kill_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a hand-driven instruction bus walks through
// streaming, wait states, stall, mid-run reset, redirects and PC wrap.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic         clk;
  logic         resetn;
  ibus_req_t    ireq;
  ibus_resp_t   iresp;
  logic         redirect_valid;
  addr_t        redirect_pc;
  logic         stall;
  logic         f_valid;
  addr_t        f_pc;
  logic [31:0]  f_instr;
  fetch_state_e dbg_state;
  addr_t        dbg_pc;
  logic         dbg_kill;

  int checks;
  int failures;

  fetch_unit #(.RESET_PC(32'hbfc0_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_instr        (f_instr),
    .dbg_state_o    (dbg_state),
    .dbg_pc_o       (dbg_pc),
    .dbg_kill_o     (dbg_kill)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic a_ok, input logic d_ok, input logic [31:0] dat);
    iresp.addr_ok = a_ok;
    iresp.data_ok = d_ok;
    iresp.data    = dat;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".f_valid"}, 32'(f_valid), 32'(v));
    if (v) begin
      chk({tag, ".f_pc"}, f_pc, pc);
      chk({tag, ".f_instr"}, f_instr, pc);
    end
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
    chk({tag, ".ireq_valid"}, 32'(ireq.valid), 32'(v));
    if (v) chk({tag, ".ireq_addr"}, ireq.addr, a);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    resetn         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    bus(1'b0, 1'b0, 32'h0);

    // Reset state
    tick();
    tick();
    chk("rst.ireq_valid", 32'(ireq.valid), 32'd0);
    chk("rst.f_valid", 32'(f_valid), 32'd0);
    chk("rst.f_pc", f_pc, 32'h0);
    chk("rst.f_instr", f_instr, 32'h0);
    chk("rst.pc", dbg_pc, 32'hbfc0_0000);
    chk("rst.kill", 32'(dbg_kill), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'(ST_READY));

    // c1: first request right after reset, zero-wait bus
    resetn = 1'b1;
    bus(1'b1, 1'b1, 32'hbfc0_0000);
    #1;
    chk_req("c1", 1'b1, 32'hbfc0_0000);
    chk_slot("c1", 1'b0, 32'h0);
    tick();
    // c2
    bus(1'b1, 1'b1, 32'hbfc0_0004);
    #1;
    chk_slot("c2", 1'b1, 32'hbfc0_0000);
    chk_req("c2", 1'b1, 32'hbfc0_0004);
    tick();
    // c3
    bus(1'b1, 1'b1, 32'hbfc0_0008);
    #1;
    chk_slot("c3", 1'b1, 32'hbfc0_0004);
    chk_req("c3", 1'b1, 32'hbfc0_0008);
    tick();
    // c4: bus stops accepting; bfc0000c will be held
    bus(1'b0, 1'b0, 32'h0);
    #1;
    chk_slot("c4", 1'b1, 32'hbfc0_0008);
    chk_req("c4", 1'b1, 32'hbfc0_000c);
    tick();
    // c5: HELD, address stable
    #1;
    chk_slot("c5", 1'b0, 32'h0);
    chk_req("c5", 1'b1, 32'hbfc0_000c);
    chk("c5.state", 32'(dbg_state), 32'(ST_HELD));
    tick();
    // c6: accepted without data
    bus(1'b1, 1'b0, 32'h0);
    #1;
    chk_req("c6", 1'b1, 32'hbfc0_000c);
    tick();
    // c7, c8: WAIT, no second request
    bus(1'b0, 1'b0, 32'h0);
    #1;
    chk_req("c7", 1'b0, 32'h0);
    chk("c7.state", 32'(dbg_state), 32'(ST_WAIT));
    tick();
    #1;
    chk_req("c8", 1'b0, 32'h0);
    chk_slot("c8", 1'b0, 32'h0);
    tick();
    // c9: data returns
    bus(1'b0, 1'b1, 32'hbfc0_000c);
    #1;
    chk_req("c9", 1'b0, 32'h0);
    tick();
    // c10: slot filled; issue bfc00010, accept without data
    bus(1'b1, 1'b0, 32'h0);
    #1;
    chk_slot("c10", 1'b1, 32'hbfc0_000c);
    chk_req("c10", 1'b1, 32'hbfc0_0010);
    tick();
    // c11: stall begins while the request is in flight; data returns
    stall = 1'b1;
    bus(1'b0, 1'b1, 32'hbfc0_0010);
    #1;
    chk_slot("c11", 1'b0, 32'h0);
    tick();
    // c12..c15: slot full and stalled, outputs frozen, no request
    bus(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_slot("stall", 1'b1, 32'hbfc0_0010);
      chk_req("stall", 1'b0, 32'h0);
      tick();
    end
    // c16: release; next PC issued, zero-wait
    stall = 1'b0;
    bus(1'b1, 1'b1, 32'hbfc0_0014);
    #1;
    chk_slot("c16", 1'b1, 32'hbfc0_0010);
    chk_req("c16", 1'b1, 32'hbfc0_0014);
    tick();
    // c17: no skip, no duplicate; next request goes to WAIT
    bus(1'b1, 1'b0, 32'h0);
    #1;
    chk_slot("c17", 1'b1, 32'hbfc0_0014);
    chk_req("c17", 1'b1, 32'hbfc0_0018);
    tick();
    // c18: WAIT; reset asserted mid-transaction
    bus(1'b0, 1'b0, 32'h0);
    resetn = 1'b0;
    #1;
    chk("c18.state", 32'(dbg_state), 32'(ST_WAIT));
    tick();
    // c19: everything back at reset values
    #1;
    chk("mrst.f_valid", 32'(f_valid), 32'd0);
    chk("mrst.f_pc", f_pc, 32'h0);
    chk("mrst.f_instr", f_instr, 32'h0);
    chk("mrst.pc", dbg_pc, 32'hbfc0_0000);
    chk("mrst.kill", 32'(dbg_kill), 32'd0);
    chk("mrst.state", 32'(dbg_state), 32'(ST_READY));
    chk("mrst.ireq_valid", 32'(ireq.valid), 32'd0);
    tick();

    // c20..c22: restart stream, then bfc00008 left pending
    resetn = 1'b1;
    bus(1'b1, 1'b1, 32'hbfc0_0000);
    #1;
    chk_req("c20", 1'b1, 32'hbfc0_0000);
    tick();
    bus(1'b1, 1'b1, 32'hbfc0_0004);
    #1;
    chk_slot("c21", 1'b1, 32'hbfc0_0000);
    tick();
    bus(1'b1, 1'b0, 32'h0);
    #1;
    chk_slot("c22", 1'b1, 32'hbfc0_0004);
    chk_req("c22", 1'b1, 32'hbfc0_0008);
    tick();
    // c23: redirect while bfc00008 is pending
    bus(1'b0, 1'b0, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    #1;
    chk_req("c23", 1'b0, 32'h0);
    tick();
    // c24: wrong-path data arrives and is discarded
    redirect_valid = 1'b0;
    bus(1'b0, 1'b1, 32'hbfc0_0008);
    #1;
    chk("c24.kill", 32'(dbg_kill), 32'd1);
    chk_slot("c24", 1'b0, 32'h0);
    chk_req("c24", 1'b0, 32'h0);
    tick();
    // c25: first request to the redirect target
    bus(1'b1, 1'b1, 32'h8000_0100);
    #1;
    chk_slot("c25", 1'b0, 32'h0);
    chk("c25.kill", 32'(dbg_kill), 32'd0);
    chk_req("c25", 1'b1, 32'h8000_0100);
    tick();
    // c26: fill and consume in the same cycle
    bus(1'b1, 1'b1, 32'h8000_0104);
    #1;
    chk_slot("c26", 1'b1, 32'h8000_0100);
    tick();
    // c27: slot replaced, f_valid stays 1; 80000108 goes to HELD
    bus(1'b0, 1'b0, 32'h0);
    #1;
    chk_slot("c27", 1'b1, 32'h8000_0104);
    chk_req("c27", 1'b1, 32'h8000_0108);
    tick();
    // c28: redirect in the same cycle as addr_ok && data_ok
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_fffc;
    bus(1'b1, 1'b1, 32'h8000_0108);
    #1;
    chk_req("c28", 1'b1, 32'h8000_0108);
    tick();
    // c29: word dropped, fetch at redirect target
    redirect_valid = 1'b0;
    bus(1'b1, 1'b1, 32'hffff_fffc);
    #1;
    chk_slot("c29", 1'b0, 32'h0);
    chk("c29.kill", 32'(dbg_kill), 32'd0);
    chk_req("c29", 1'b1, 32'hffff_fffc);
    tick();
    // c30: PC wraps to zero
    bus(1'b1, 1'b1, 32'h0000_0000);
    #1;
    chk_slot("c30", 1'b1, 32'hffff_fffc);
    chk_req("c30", 1'b1, 32'h0000_0000);
    tick();
    // c31: address 4 will be held
    bus(1'b0, 1'b0, 32'h0);
    #1;
    chk_slot("c31", 1'b1, 32'h0000_0000);
    chk_req("c31", 1'b1, 32'h0000_0004);
    tick();
    // c32: redirect during HELD
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    #1;
    chk_req("c32", 1'b1, 32'h0000_0004);
    tick();
    // c33: held address still presented; accepted without data
    redirect_valid = 1'b0;
    bus(1'b1, 1'b0, 32'h0);
    #1;
    chk_req("c33", 1'b1, 32'h0000_0004);
    chk("c33.kill", 32'(dbg_kill), 32'd1);
    tick();
    // c34: its response is discarded
    bus(1'b0, 1'b1, 32'h0000_0004);
    #1;
    chk_req("c34", 1'b0, 32'h0);
    tick();
    // c35: nothing filled, fetch resumes at the redirect target
    bus(1'b0, 1'b0, 32'h0);
    #1;
    chk_slot("c35", 1'b0, 32'h0);
    chk_req("c35", 1'b1, 32'h8000_0200);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS pipeline, directly upstream of pre-decode. Owns the PC register and drives the instruction bus with at most one outstanding request. Captures returned instruction words into a one-entry output slot that pre-decode consumes as `{f_pc, f_instr}`. Handles back-end redirects (branch/jump resolution) by flushing the slot and discarding in-flight wrong-path responses.

## Interface
- `RESET_PC`, default 32'hbfc0_0000: first fetch address after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  **synchronous, active-low reset**.
- `ireq`  out  ibus_req_t  `ireq.valid` and `ireq.addr`; all other fields are 0.
- `iresp`  in  ibus_resp_t  uses `addr_ok`, `data_ok`, `data[31:0]`.
- `redirect_valid`  in  1  back end requests a PC change this cycle.
- `redirect_pc`  in  addr_t  new fetch address; bits [1:0] are 0.
- `stall`  in  1  pre-decode cannot accept the slot this cycle.
- `f_valid`  out  1  output slot holds a valid instruction.
- `f_pc`  out  addr_t  PC of the slot instruction (to pre-decode PC input).
- `f_instr`  out  32  instruction word (to pre-decode data input).

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `state`: READY / HELD / WAIT.
  - `kill`: discard the pending response.
  - Output slot: `f_valid`, `f_pc`, `f_instr`.
- `slot_free = !f_valid || !stall`. The slot is consumed in any cycle with `f_valid && !stall`.
- READY:
  - `ireq.valid = slot_free && !redirect_valid` (combinational), with `ireq.addr = pc`.
  - If valid and `addr_ok && data_ok`: fill the slot with `{pc, data}` and set `pc += 4`. Stay READY.
  - If valid and only `addr_ok`: go to WAIT and set `pc += 4`. The captured-address register keeps the old pc for the slot.
  - If valid and no `addr_ok`: go to HELD.
- HELD:
  - `ireq.valid = 1` and `ireq.addr` stays stable (bus rule: never drop or change before `addr_ok`).
  - On `addr_ok`, follow the same transitions as READY.
- WAIT:
  - `ireq.valid = 0`.
  - On `data_ok`: fill the slot with `{req_addr, data}` unless `kill`. Clear `kill` and go to READY.
- Redirect (any state):
  - `f_valid <= 0`.
  - `pc <= redirect_pc`.
  - If a request is presented-but-unaccepted, accepted-and-pending, or completing this same cycle, its data is discarded. `kill <= 1` if a response is still owed.
  - If a redirect arrives during HELD, the held address is still presented until `addr_ok`. Its response is then discarded.
  - Latest redirect wins. A second redirect while `kill` is set only updates `pc`.
- Slot fill and slot consume in the same cycle: the new entry wins and `f_valid` stays 1.
- `pc` arithmetic is 32-bit modulo. 32'hffff_fffc + 4 wraps to 0.
- `data_ok` without an outstanding request is ignored (protocol violation; covered by an assertion).

## Timing
- Reset (`resetn = 0` at an edge):
  - `pc = RESET_PC`, state READY, `kill = 0`.
  - `f_valid = 0`, `f_pc = 0`, `f_instr = 0`.
  - `ireq.valid` is 0 during reset cycles.
  - A reset mid-transaction abandons the request. The bus is reset alongside, so no response is expected.
- First `ireq.valid` appears in the first cycle after `resetn` goes high.
- Latency:
  - Zero-wait bus: request in cycle n gives `f_valid` in n+1.
  - Sustained throughput is 1 instr/cycle when `stall = 0`.
- Bus with `addr_ok` at n and `data_ok` at n+k: `f_valid` at n+k+1. The next request is issued at n+k+1 at the earliest.
- Redirect in cycle n:
  - `f_valid = 0` at n+1.
  - If idle, the first request to `redirect_pc` is issued at n+1.
  - If a response is owed, the request is issued the cycle after the discarded `data_ok`.
- `stall` held: `f_valid`, `f_pc`, `f_instr` remain stable. No new request is issued while the slot is full and not draining.

## Test plan
- **Reset and stream:** reset, then a zero-wait bus returning `data = addr`, `stall = 0`.
  - First `ireq.addr = bfc00000` in cycle 1.
  - `f_pc` = bfc00000, bfc00004, bfc00008 on consecutive cycles.
  - `f_instr = f_pc`.
- **Wait states:** `addr_ok` delayed 2 cycles, `data_ok` delayed 3 cycles after `addr_ok`.
  - `ireq.addr` stays stable while `ireq.valid` is held.
  - Exactly one outstanding request at a time.
  - Each `f_pc` appears once, in order.
- **Stall:** `stall = 1` for 5 cycles with the slot full.
  - Outputs frozen.
  - `ireq.valid = 0` after the in-flight request completes.
  - Release gives the next PC with no skip and no duplicate.
- **Redirect during WAIT:** redirect to 80000100 while the request to bfc00008 is pending.
  - The bfc00008 data never appears on `f_valid`.
  - Next `f_pc = 80000100`.
- **Simultaneous events:**
  - Redirect in the same cycle as `addr_ok && data_ok`: that word is dropped and the next fetch is at `redirect_pc`.
  - Fill and consume in the same cycle keep `f_valid = 1`.
  - `pc` at fffffffc wraps to 00000000.
- **Mid-run reset:** reset asserted in WAIT.
  - Next cycle: all outputs at reset values, `pc = RESET_PC`, `kill = 0`.
